correlator_packet_tx: RTL and testbench
=======================================

// Module: correlator_packet_tx
// PURPOSE
//  Transmit side of the correlator readout. Snapshots the accumulated correlation payload bus plus a timestamp,
//  frames it as header | payload | footer, emits it byte-serially (ASCII hex or raw binary) to the UART byte sink.
//  Pulses clear_acc once per snapshot to restart integration; sits between correlator and uart_tx.
// PARAMETERS
//  PAYLOAD_SIZE  64  payload bus width in bits; multiple of 8
//  BINARY        0   0: ASCII hex, 2 chars/byte, CR LF terminator; 1: raw bytes, no terminator
//  SYNC_WORD     16'hAA55  footer marker
// PORTS
//  clk        in   1             clock
//  reset      in   1             synchronous, active-high
//  start      in   1             request snapshot+transmit; accepted only in IDLE
//  payload    in   PAYLOAD_SIZE  correlator accumulators, sampled on accepted start
//  timestamp  in   64            sampled on accepted start
//  busy       out  1             high from accepted start until last byte handshaked
//  clear_acc  out  1             one-cycle pulse, cycle after accepted start
//  tx_data    out  8             byte to UART
//  tx_valid   out  1             tx_data valid
//  tx_ready   in   1             UART accepts byte when tx_valid&tx_ready
//  pkt_done   out  1             one-cycle pulse, cycle after final byte transfer
// BEHAVIOUR
//  Reset: busy=0, clear_acc=0, tx_valid=0, tx_data=0, pkt_done=0, seq=0, checksum=0, state=IDLE; abandons packet in flight.
//  Frame MSB first: header=timestamp[63:0]; payload[PAYLOAD_SIZE-1:0]; footer={SYNC_WORD, seq[15:0], checksum[31:0]}.
//  FSM: IDLE -> HEADER (8 B) -> PAYLOAD (PAYLOAD_SIZE/8 B) -> FOOTER (8 B) -> [EOL (CR,LF) if BINARY=0] -> IDLE.
//  Hex: each byte sent as two chars, high nibble first; 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
//  Byte count: BINARY=1 -> 16+PAYLOAD_SIZE/8; BINARY=0 -> 2*(16+PAYLOAD_SIZE/8)+2.
//  Latency: start sampled cycle N -> busy=1 and shadow loaded at N+1, clear_acc=1 at N+1, tx_valid=1 at N+1.
//  Handshake: tx_data/tx_valid held stable while tx_valid&~tx_ready; next byte presented cycle after transfer,
//   no bubble when tx_ready held high (one byte per cycle).
//  start while busy: ignored, no clear_acc, payload not resampled. start same cycle as final transfer: ignored.
//  seq: 16-bit, increments at pkt_done, wraps 16'hFFFF -> 0; footer carries pre-increment value.
//  checksum: 32-bit wrapping sum of raw payload bytes (not header/footer, not ASCII), cleared on accepted start.
//  Payload input may change freely after the sampling cycle; output built only from shadow registers.
// CONFIGURATION
//  CORRELATOR_TX_CHECKSUM_EN defined: footer[31:0]=checksum as above.
//  Not defined: footer[31:0]=32'h0, no adder instantiated; framing, length, timing unchanged.
// STRUCTURE
//  correlator_pkg: HEADER_SIZE=64, FOOTER_SIZE=64, ASCII_CR=8'h0D, ASCII_LF=8'h0A, tx_state_t enum
//   {IDLE,HEADER,PAYLOAD,FOOTER,EOL}, function hex_ascii(nibble)->byte.
//  Sub-module tx_byte_shifter: loadable shift register (width param), shifts 8 bits MSB-first on advance,
//   zero-fills, instantiated for header, payload and footer shadows.
// TESTING
//  BINARY=1, PAYLOAD_SIZE=16, ts=64'h1, payload=16'h12AB, tx_ready=1 -> 18 bytes: 00x7 01 12 AB AA 55 00 00 00 00 00 BD; pkt_done once.
//  BINARY=0 same stimulus -> "0000000000000001" "12AB" "AA550000000000BD" 0D 0A (38 chars); clear_acc exactly 1 cycle at N+1.
//  tx_ready toggled randomly (50%) -> identical byte stream, tx_data stable while stalled, no drops/dupes.
//  Two packets back-to-back, start reasserted while busy -> second start ignored; next accepted packet footer seq=0001.
//  reset asserted mid-PAYLOAD -> next cycle tx_valid=0, busy=0; following packet seq=0000, checksum fresh.
//  Macro undefined, payload=16'hFFFF -> footer low 32 bits = 00000000; defined -> 000001FE.

Source files
------------

// File: rtl/correlator_pkg.sv
// correlator_pkg
//   Shared definitions for the correlator readout transmit path: frame section
//   sizes, ASCII line terminator bytes, the transmit FSM state type and the
//   nibble-to-ASCII-hex helper.
package correlator_pkg;

    localparam int HEADER_SIZE = 64;
    localparam int FOOTER_SIZE = 64;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        FOOTER,
        EOL
    } tx_state_t;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/correlator_packet_tx_shifter.sv
// tx_byte_shifter
//   Loadable shadow register that presents its most significant byte and
//   shifts left by one byte per advance, zero-filling from the bottom.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears the shadow)
//   load         capture load_value (has priority over advance)
//   load_value   WIDTH-bit value to capture
//   advance      drop the current top byte and expose the next one
//   top_byte     current most significant byte
module tx_byte_shifter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             advance,
    output logic [7:0]       top_byte
);

    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= load_value;
        end else if (advance) begin
            shadow <= shadow << 8;
        end
    end

    assign top_byte = shadow[WIDTH-1 -: 8];

endmodule

// File: rtl/correlator_packet_tx.sv
// correlator_packet_tx
//   Snapshots the correlator payload and a timestamp on an accepted start,
//   then streams header | payload | footer byte-serially to the UART sink,
//   either as raw bytes (BINARY=1) or as uppercase ASCII hex followed by CR LF
//   (BINARY=0). clear_acc pulses once per snapshot to restart integration.
//   Footer = {SYNC_WORD, seq, checksum}.
// Configuration:
//   CORRELATOR_TX_CHECKSUM_EN  when defined, footer[31:0] carries the 32-bit
//                              wrapping sum of the raw payload bytes; otherwise
//                              it is zero and no adder is built.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             snapshot request, accepted only when idle
//   payload           correlator accumulators (PAYLOAD_SIZE bits)
//   timestamp         64-bit timestamp
//   busy              high from accepted start until the last byte handshake
//   clear_acc         one-cycle pulse the cycle after an accepted start
//   tx_data/tx_valid  byte stream to the UART, tx_ready handshake
//   pkt_done          one-cycle pulse the cycle after the final transfer
module correlator_packet_tx
    import correlator_pkg::*;
#(
    parameter int          PAYLOAD_SIZE = 64,
    parameter int          BINARY       = 0,
    parameter logic [15:0] SYNC_WORD    = 16'hAA55
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PAYLOAD_SIZE-1:0] payload,
    input  logic [63:0]             timestamp,
    output logic                    busy,
    output logic                    clear_acc,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    pkt_done
);

    localparam logic [15:0] HEADER_LAST  = 16'(HEADER_SIZE / 8 - 1);
    localparam logic [15:0] PAYLOAD_LAST = 16'(PAYLOAD_SIZE / 8 - 1);
    localparam logic [15:0] FOOTER_LAST  = 16'(FOOTER_SIZE / 8 - 1);
    localparam logic        IS_BINARY    = (BINARY != 0);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] byte_cnt;
    logic        nibble_sel;
    logic [15:0] seq;
    logic [7:0]  header_byte;
    logic [7:0]  payload_byte;
    logic [7:0]  footer_byte;
    logic [7:0]  raw_byte;
    logic        section_end;
    logic        xfer;
    logic        byte_done;
    logic        accept;
    logic        final_xfer;
    logic        header_adv;
    logic        payload_adv;
    logic        footer_load;
    logic [31:0] footer_check;

    assign tx_valid = (state != IDLE);
    assign busy     = tx_valid;
    assign xfer     = tx_valid & tx_ready;
    // In hex mode (and in EOL) a frame byte is finished only when its second
    // character is accepted; nibble_sel marks that second character.
    assign byte_done   = xfer & (IS_BINARY | nibble_sel);
    assign accept      = (state == IDLE) & start;
    assign final_xfer  = byte_done & (state_next == IDLE);
    assign header_adv  = byte_done & (state == HEADER);
    assign payload_adv = byte_done & (state == PAYLOAD);
    // The footer is captured as the last payload byte leaves so that the
    // checksum already includes that byte.
    assign footer_load = payload_adv & section_end;

`ifdef CORRELATOR_TX_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] checksum_next;

    assign checksum_next = checksum + {24'h0, payload_byte};
    assign footer_check  = checksum_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= 32'h0;
        end else if (accept) begin
            checksum <= 32'h0;
        end else if (payload_adv) begin
            checksum <= checksum_next;
        end
    end
`else
    assign footer_check = 32'h0;
`endif

    tx_byte_shifter #(.WIDTH(HEADER_SIZE)) u_header_shadow (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (timestamp),
        .advance    (header_adv),
        .top_byte   (header_byte)
    );

    tx_byte_shifter #(.WIDTH(PAYLOAD_SIZE)) u_payload_shadow (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (payload),
        .advance    (payload_adv),
        .top_byte   (payload_byte)
    );

    tx_byte_shifter #(.WIDTH(FOOTER_SIZE)) u_footer_shadow (
        .clk        (clk),
        .reset      (reset),
        .load       (footer_load),
        .load_value ({SYNC_WORD, seq, footer_check}),
        .advance    (byte_done & (state == FOOTER)),
        .top_byte   (footer_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        raw_byte    = 8'h00;
        section_end = 1'b0;
        tx_data     = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                raw_byte    = header_byte;
                section_end = (byte_cnt == HEADER_LAST);
                if (byte_done && section_end) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                raw_byte    = payload_byte;
                section_end = (byte_cnt == PAYLOAD_LAST);
                if (byte_done && section_end) begin
                    state_next = FOOTER;
                end
            end
            FOOTER: begin
                raw_byte    = footer_byte;
                section_end = (byte_cnt == FOOTER_LAST);
                if (byte_done && section_end) begin
                    state_next = IS_BINARY ? IDLE : EOL;
                end
            end
            EOL: begin
                section_end = 1'b1;
                if (byte_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state == EOL) begin
            tx_data = nibble_sel ? ASCII_LF : ASCII_CR;
        end else if (state != IDLE) begin
            if (IS_BINARY) begin
                tx_data = raw_byte;
            end else begin
                tx_data = nibble_sel ? hex_ascii(raw_byte[3:0]) : hex_ascii(raw_byte[7:4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= 16'd0;
            nibble_sel <= 1'b0;
            seq        <= 16'd0;
            clear_acc  <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            clear_acc <= accept;
            pkt_done  <= final_xfer;
            if (pkt_done) begin
                seq <= seq + 16'd1;
            end
            if (accept) begin
                byte_cnt   <= 16'd0;
                nibble_sel <= 1'b0;
            end else if (byte_done) begin
                nibble_sel <= 1'b0;
                byte_cnt   <= section_end ? 16'd0 : byte_cnt + 16'd1;
            end else if (xfer) begin
                nibble_sel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_correlator_packet_tx.sv
// tb_correlator_packet_tx
//   Drives a raw-binary and an ASCII-hex instance (PAYLOAD_SIZE=16) from the
//   same start/payload/timestamp/reset, each with its own tx_ready. A frame
//   model builds the expected byte list per accepted start and a single
//   negedge process compares every cycle; literal frames pin the model.
module tb_correlator_packet_tx;

    localparam int PS = 16;
    typedef logic [7:0] byte_q_t [$];

`ifdef CORRELATOR_TX_CHECKSUM_EN
    localparam logic [31:0] CK_12AB = 32'h000000BD;
    localparam logic [31:0] CK_FFFF = 32'h000001FE;
    localparam logic [31:0] CK_0102 = 32'h00000003;
`else
    localparam logic [31:0] CK_12AB = 32'h0;
    localparam logic [31:0] CK_FFFF = 32'h0;
    localparam logic [31:0] CK_0102 = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PS-1:0] payload = '0;
    logic [63:0]   timestamp = '0;
    logic          bin_ready = 1'b1;
    logic          hex_ready = 1'b1;
    logic          bin_busy, bin_clear, bin_valid, bin_done;
    logic          hex_busy, hex_clear, hex_valid, hex_done;
    logic [7:0]    bin_data, hex_data;

    int      compared = 0;
    int      mismatched = 0;
    bit      checking = 1'b0;
    bit      rand_ready = 1'b0;
    bit      m_busy [2];
    bit      m_clear [2];
    bit      m_done [2];
    logic [15:0] m_seq [2];
    byte_q_t exp_bin, exp_hex, cap_bin, cap_hex;
    int      clear_cnt [2];
    int      done_cnt [2];

    always #5 clk = ~clk;

    correlator_packet_tx #(.PAYLOAD_SIZE(PS), .BINARY(1), .SYNC_WORD(16'hAA55)) dut_bin (
        .clk(clk), .reset(reset), .start(start), .payload(payload), .timestamp(timestamp),
        .busy(bin_busy), .clear_acc(bin_clear), .tx_data(bin_data), .tx_valid(bin_valid),
        .tx_ready(bin_ready), .pkt_done(bin_done)
    );

    correlator_packet_tx #(.PAYLOAD_SIZE(PS), .BINARY(0), .SYNC_WORD(16'hAA55)) dut_hex (
        .clk(clk), .reset(reset), .start(start), .payload(payload), .timestamp(timestamp),
        .busy(hex_busy), .clear_acc(hex_clear), .tx_data(hex_data), .tx_valid(hex_valid),
        .tx_ready(hex_ready), .pkt_done(hex_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    function automatic byte_q_t build_packet(input bit binary, input logic [63:0] ts,
                                             input logic [PS-1:0] pl, input logic [15:0] sq);
        byte_q_t raw;
        byte_q_t out;
        logic [31:0] sum;
        sum = 32'h0;
        for (int i = 7; i >= 0; i--) raw.push_back(ts[i*8 +: 8]);
        for (int i = PS/8 - 1; i >= 0; i--) begin
            raw.push_back(pl[i*8 +: 8]);
            sum = sum + 32'(pl[i*8 +: 8]);
        end
`ifndef CORRELATOR_TX_CHECKSUM_EN
        sum = 32'h0;
`endif
        raw.push_back(8'hAA);
        raw.push_back(8'h55);
        raw.push_back(sq[15:8]);
        raw.push_back(sq[7:0]);
        for (int i = 3; i >= 0; i--) raw.push_back(sum[i*8 +: 8]);
        if (binary) return raw;
        foreach (raw[k]) begin
            out.push_back(hex_char(raw[k][7:4]));
            out.push_back(hex_char(raw[k][3:0]));
        end
        out.push_back(8'h0D);
        out.push_back(8'h0A);
        return out;
    endfunction

    function automatic logic [7:0] capget(input int which, input int k);
        if (which == 0) return (k < cap_bin.size()) ? cap_bin[k] : 8'hxx;
        return (k < cap_hex.size()) ? cap_hex[k] : 8'hxx;
    endfunction

    always @(posedge clk) begin
        #1;
        bin_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        hex_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare DUT outputs against the frame model, then advance the model to
    // what the next rising edge will do with the inputs now present.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                logic a_busy, a_valid, a_clear, a_done, a_rdy;
                logic [7:0] a_data, front;
                bit was_busy;
                string tag;
                tag = (i == 0) ? "bin" : "hex";
                if (i == 0) begin
                    a_busy = bin_busy; a_valid = bin_valid; a_clear = bin_clear;
                    a_done = bin_done; a_rdy = bin_ready; a_data = bin_data;
                    front = (exp_bin.size() > 0) ? exp_bin[0] : 8'hxx;
                end else begin
                    a_busy = hex_busy; a_valid = hex_valid; a_clear = hex_clear;
                    a_done = hex_done; a_rdy = hex_ready; a_data = hex_data;
                    front = (exp_hex.size() > 0) ? exp_hex[0] : 8'hxx;
                end
                checkOutput({tag, " busy"}, a_busy, m_busy[i]);
                checkOutput({tag, " tx_valid"}, a_valid, m_busy[i]);
                checkOutput({tag, " clear_acc"}, a_clear, m_clear[i]);
                checkOutput({tag, " pkt_done"}, a_done, m_done[i]);
                if (m_busy[i]) checkOutput({tag, " tx_data"}, a_data, front);
                if (a_valid === 1'b1 && a_rdy) begin
                    if (i == 0) cap_bin.push_back(a_data); else cap_hex.push_back(a_data);
                end
                if (a_clear === 1'b1) clear_cnt[i]++;
                if (a_done === 1'b1) done_cnt[i]++;

                was_busy = m_busy[i];
                m_clear[i] = 1'b0;
                m_done[i] = 1'b0;
                if (reset) begin
                    m_busy[i] = 1'b0;
                    m_seq[i] = 16'h0;
                    if (i == 0) exp_bin.delete(); else exp_hex.delete();
                end else begin
                    if (was_busy && a_rdy) begin
                        int left;
                        if (i == 0) begin void'(exp_bin.pop_front()); left = exp_bin.size(); end
                        else begin void'(exp_hex.pop_front()); left = exp_hex.size(); end
                        if (left == 0) begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                            m_seq[i] = m_seq[i] + 16'h1;
                        end
                    end
                    if (!was_busy && start) begin
                        if (i == 0) exp_bin = build_packet(1'b1, timestamp, payload, m_seq[i]);
                        else        exp_hex = build_packet(1'b0, timestamp, payload, m_seq[i]);
                        m_busy[i] = 1'b1;
                        m_clear[i] = 1'b1;
                    end
                end
            end
        end
    end

    // One-edge start pulse; payload is scrambled afterwards to prove the
    // frame comes from the snapshot.
    task automatic applyStimulus(input logic [63:0] ts, input logic [PS-1:0] pl);
        timestamp = ts;
        payload = pl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        payload = ~pl;
        timestamp = ~ts;
    endtask

    task automatic clearCapture();
        cap_bin.delete();
        cap_hex.delete();
        clear_cnt[0] = 0; clear_cnt[1] = 0;
        done_cnt[0] = 0;  done_cnt[1] = 0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1] || bin_busy !== 1'b0 || hex_busy !== 1'b0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, " completes within budget"}, 64'(n < budget), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic checkBinBytes(input string name, input int first, input logic [63:0] value, input int count);
        for (int k = 0; k < count; k++) begin
            checkOutput($sformatf("%s byte %0d", name, first + k), capget(0, first + k),
                        64'(value[(count-1-k)*8 +: 8]));
        end
    endtask

    initial begin
        string hex_a;
        logic [143:0] lit_a;

        m_seq[0] = 16'h0; m_seq[1] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        @(negedge clk);
        checkOutput("reset bin tx_data", bin_data, 8'h00);
        checkOutput("reset hex tx_data", hex_data, 8'h00);
        checkOutput("reset bin tx_valid", bin_valid, 1'b0);
        checkOutput("reset hex busy", hex_busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] packet A: ts=1 payload=12AB, tx_ready high");
        clearCapture();
        applyStimulus(64'h1, 16'h12AB);
        @(negedge clk);
        checkOutput("A bin clear_acc at N+1", bin_clear, 1'b1);
        checkOutput("A hex busy at N+1", hex_busy, 1'b1);
        checkOutput("A bin first byte", bin_data, 8'h00);
        checkOutput("A hex first char", hex_data, 8'h30);
        @(posedge clk); #1;
        waitIdle("A", 200);
        lit_a = {64'h1, 16'h12AB, 16'hAA55, 16'h0000, CK_12AB};
        checkOutput("A bin length", cap_bin.size(), 18);
        checkBinBytes("A bin", 0, lit_a[143:80], 8);
        checkBinBytes("A bin", 8, lit_a[79:16], 8);
        checkBinBytes("A bin", 16, 64'(lit_a[15:0]), 2);
        hex_a = {"0000000000000001", "12AB", "AA550000", $sformatf("%08X", CK_12AB)};
        checkOutput("A hex length", cap_hex.size(), 38);
        for (int k = 0; k < 36; k++) checkOutput($sformatf("A hex char %0d", k), capget(1, k), 64'(hex_a[k]));
        checkOutput("A hex CR", capget(1, 36), 8'h0D);
        checkOutput("A hex LF", capget(1, 37), 8'h0A);
        checkOutput("A bin clear_acc pulses", clear_cnt[0], 1);
        checkOutput("A hex clear_acc pulses", clear_cnt[1], 1);
        checkOutput("A bin pkt_done pulses", done_cnt[0], 1);
        checkOutput("A hex pkt_done pulses", done_cnt[1], 1);

        $display("[TB] packet B: random tx_ready");
        clearCapture();
        rand_ready = 1'b1;
        applyStimulus(64'h0123456789ABCDEF, 16'h8001);
        waitIdle("B", 800);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("B bin length", cap_bin.size(), 18);
        checkOutput("B hex length", cap_hex.size(), 38);
        checkBinBytes("B bin", 0, 64'h0123456789ABCDEF, 8);
        checkBinBytes("B bin seq", 12, 64'h0001, 2);

        $display("[TB] packet C: start coinciding with final transfer");
        clearCapture();
        applyStimulus(64'hFEDCBA9876543210, 16'h00FF);
        repeat (17) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("C bin busy after final", bin_busy, 1'b0);
        checkOutput("C bin pkt_done after final", bin_done, 1'b1);
        checkOutput("C bin no clear_acc", bin_clear, 1'b0);
        @(posedge clk); #1;
        waitIdle("C", 200);
        checkOutput("C bin clear_acc pulses", clear_cnt[0], 1);
        checkOutput("C hex clear_acc pulses", clear_cnt[1], 1);

        $display("[TB] reset during payload");
        clearCapture();
        applyStimulus(64'h1111111111111111, 16'h5A5A);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("R bin tx_valid after reset", bin_valid, 1'b0);
        checkOutput("R bin busy after reset", bin_busy, 1'b0);
        checkOutput("R hex tx_valid after reset", hex_valid, 1'b0);
        @(posedge clk); #1;
        clearCapture();
        applyStimulus(64'h2, 16'hFFFF);
        waitIdle("R", 200);
        checkBinBytes("R bin payload", 8, 64'hFFFF, 2);
        checkBinBytes("R bin seq", 12, 64'h0000, 2);
        checkBinBytes("R bin checksum", 14, 64'(CK_FFFF), 4);

        $display("[TB] back-to-back: second start while busy");
        clearCapture();
        applyStimulus(64'h3, 16'h0102);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(64'h4, 16'h0304);
        waitIdle("D", 200);
        checkOutput("D bin clear_acc pulses", clear_cnt[0], 1);
        checkOutput("D hex clear_acc pulses", clear_cnt[1], 1);
        checkOutput("D bin length", cap_bin.size(), 18);
        checkBinBytes("D bin ts", 0, 64'h3, 8);
        checkBinBytes("D bin payload", 8, 64'h0102, 2);
        checkBinBytes("D bin seq", 12, 64'h0001, 2);
        checkBinBytes("D bin checksum", 14, 64'(CK_0102), 4);
        clearCapture();
        applyStimulus(64'h5, 16'h0304);
        waitIdle("E", 200);
        checkBinBytes("E bin payload", 8, 64'h0304, 2);
        checkBinBytes("E bin seq", 12, 64'h0002, 2);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
